// File: rtl/bus_hub_n.sv
// Single-host, N-device bus hub: latch one host request, broadcast it, strobe the lowest active device.
// Latency: 3 cycles minimum (request -> select -> access -> response), 2 cycles for an unmapped error.
// Backpressure: the host waits for host_ready. Pulses that arrive while busy are dropped, and devices stall via device_ready.
module bus_hub_n #(
  parameter int          N_DEVICES      = 4,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             host_address,
  input  logic [31:0]             host_data_write,
  input  logic [3:0]              host_write_mask,
  input  logic                    host_wen,
  input  logic                    host_ren,
  output logic [31:0]             host_data_read,
  output logic                    host_ready,
  output logic                    host_error,
  output logic [32*N_DEVICES-1:0] device_address,
  output logic [32*N_DEVICES-1:0] device_data_write,
  output logic [4*N_DEVICES-1:0]  device_write_mask,
  output logic [N_DEVICES-1:0]    device_wen,
  output logic [N_DEVICES-1:0]    device_ren,
  input  logic [N_DEVICES-1:0]    device_ready,
  input  logic [32*N_DEVICES-1:0] device_data_read,
  input  logic [N_DEVICES-1:0]    device_active
);

  localparam int SW = (N_DEVICES > 1) ? $clog2(N_DEVICES) : 1;
  // A zero-width counter is illegal, so the counter keeps one bit even when the timeout is disabled.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SELECT, ACCESS, RESP} state_t;

  state_t          state_q, state_d;
  logic [31:0]     lat_addr, lat_wdat;
  logic [3:0]      lat_mask;
  logic            lat_wr;
  logic [SW-1:0]   sel_q, pick;
  logic            any_act;
  logic            sel_rdy;
  logic [31:0]     sel_rdat;
  logic [CW-1:0]   cnt_q;
  logic            tmo_hit;
  logic            err_q;
  logic [31:0]     rdata_q;
  logic            req;

  assign req     = host_wen | host_ren;
  assign tmo_hit = TMO_EN && (cnt_q == TMO_LAST);

  // Lowest-index active device wins. Scanning downward leaves the smallest index in pick.
  always_comb begin
    any_act = 1'b0;
    pick    = '0;
    for (int i = N_DEVICES - 1; i >= 0; i--) begin
      if (device_active[i]) begin
        any_act = 1'b1;
        pick    = SW'(i);
      end
    end
  end

  // Mux the ready and read data of the selected device only. Other devices' ready is ignored.
  always_comb begin
    sel_rdy  = 1'b0;
    sel_rdat = '0;
    for (int i = 0; i < N_DEVICES; i++) begin
      if (sel_q == SW'(i)) begin
        sel_rdy  = device_ready[i];
        sel_rdat = device_data_read[32*i +: 32];
      end
    end
  end

  // State register. Async reset returns to IDLE, which kills the strobes without waiting for an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic. Ready takes priority over a timeout landing in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = SELECT;
      SELECT:  state_d = any_act ? ACCESS : RESP;
      ACCESS:  if (sel_rdy || tmo_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: request latch, device select, timeout counter and the registered response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_addr <= '0;
      lat_wdat <= '0;
      lat_mask <= '0;
      lat_wr   <= 1'b0;
      sel_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            lat_addr <= host_address;
            lat_wdat <= host_data_write;
            lat_mask <= host_write_mask;
            lat_wr   <= host_wen;
          end
        end
        SELECT: begin
          if (any_act) begin
            sel_q <= pick;
            cnt_q <= '0;
          end else begin
            err_q   <= 1'b1;
            rdata_q <= ERR_DATA;
          end
        end
        ACCESS: begin
          if (sel_rdy) begin
            err_q   <= 1'b0;
            rdata_q <= lat_wr ? 32'h0 : sel_rdat;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            rdata_q <= ERR_DATA;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Only the selected device is strobed, and only while in ACCESS.
  always_comb begin
    device_wen = '0;
    device_ren = '0;
    if (state_q == ACCESS) begin
      for (int i = 0; i < N_DEVICES; i++) begin
        if (sel_q == SW'(i)) begin
          device_wen[i] = lat_wr;
          device_ren[i] = ~lat_wr;
        end
      end
    end
  end

  assign device_address    = {N_DEVICES{lat_addr}};
  assign device_data_write = {N_DEVICES{lat_wdat}};
  assign device_write_mask = {N_DEVICES{lat_mask}};
  assign host_ready        = (state_q == RESP);
  assign host_error        = (state_q == RESP) && err_q;
  assign host_data_read    = rdata_q;

endmodule

// File: tb/tb_bus_hub_n.sv
`timescale 1ns/1ps
module tb_bus_hub_n;
  localparam int N = 4;
  localparam int T = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   host_address = '0;
  logic [31:0]   host_data_write = '0;
  logic [3:0]    host_write_mask = '0;
  logic          host_wen = 1'b0;
  logic          host_ren = 1'b0;
  logic [31:0]   host_data_read;
  logic          host_ready;
  logic          host_error;
  logic [32*N-1:0] device_address;
  logic [32*N-1:0] device_data_write;
  logic [4*N-1:0]  device_write_mask;
  logic [N-1:0]    device_wen;
  logic [N-1:0]    device_ren;
  logic [N-1:0]    device_ready;
  logic [32*N-1:0] device_data_read;
  logic [N-1:0]    device_active;

  typedef struct { logic [31:0] data; logic err; } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Device model state: read data, ready delay (strobe cycles, 0 = never), forced ready, strobe counter.
  logic [31:0] rd_data[N];
  int          delay[N];
  logic        force_rdy[N];
  int          scnt[N];

  bus_hub_n #(.N_DEVICES(N), .TIMEOUT_CYCLES(T), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst(rst),
    .host_address(host_address), .host_data_write(host_data_write),
    .host_write_mask(host_write_mask), .host_wen(host_wen), .host_ren(host_ren),
    .host_data_read(host_data_read), .host_ready(host_ready), .host_error(host_error),
    .device_address(device_address), .device_data_write(device_data_write),
    .device_write_mask(device_write_mask), .device_wen(device_wen), .device_ren(device_ren),
    .device_ready(device_ready), .device_data_read(device_data_read),
    .device_active(device_active)
  );

  always #5 clk = ~clk;

  // Address decode: nibble [15:12] picks the device; 0x3xxx hits both dev0 and dev3.
  always_comb begin
    logic [3:0] nib;
    device_active = '0;
    for (int i = 0; i < N; i++) begin
      nib = device_address[32*i+12 +: 4];
      device_active[i] = (nib == 4'(i)) || (i == 0 && nib == 4'd3);
    end
  end

  always_comb begin
    device_data_read = '0;
    device_ready     = '0;
    for (int i = 0; i < N; i++) begin
      device_data_read[32*i +: 32] = rd_data[i];
      device_ready[i] = force_rdy[i] ||
        ((device_wen[i] || device_ren[i]) && delay[i] != 0 && scnt[i] + 1 == delay[i]);
    end
  end

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < N; i++) begin
      if (!rst) scnt[i] <= 0;
      else      scnt[i] <= (device_wen[i] || device_ren[i]) ? scnt[i] + 1 : 0;
    end
  end

  // Scoreboard: every response is matched against the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst && host_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ready: got a response, required none");
      end else begin
        e = sb.pop_front();
        if (host_data_read !== e.data || host_error !== e.err) begin
          n_fail++;
          $display("FAIL response: got data %h err %b, required data %h err %b",
                   host_data_read, host_error, e.data, e.err);
        end
      end
    end
  end

  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wdat,
                         input logic [3:0] mask, input logic [31:0] exp_data, input logic exp_err,
                         input int extra_at, output int lat, output int strobe_cnt,
                         output logic [3:0] wen_or, output logic [3:0] ren_or);
    exp_t e;
    @(negedge clk);
    host_address = addr; host_data_write = wdat; host_write_mask = mask;
    host_wen = wr; host_ren = ~wr;
    e.data = exp_data; e.err = exp_err;
    sb.push_back(e);
    lat = -1; strobe_cnt = 0; wen_or = '0; ren_or = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      host_wen = 1'b0; host_ren = 1'b0;
      if (k == extra_at) host_ren = 1'b1;
      if ((device_wen | device_ren) != '0) strobe_cnt++;
      wen_or |= device_wen; ren_or |= device_ren;
      if (host_ready) begin lat = k; break; end
    end
    host_ren = 1'b0;
    if (lat < 0) begin
      n_tests++; n_fail++;
      $display("FAIL txn_timeout: got no host_ready in 40 cycles, required a response");
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (host_ready !== 1'b0 || host_error !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b/%b, required 0/0", host_ready, host_error);
    end
    n_tests++;
    if ((device_wen | device_ren) !== '0) begin
      n_fail++; $display("FAIL reset_strobe: got %b/%b, required 0", device_wen, device_ren);
    end
    n_tests++;
    if (host_data_read !== 32'h0 || device_address !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h addr %h, required 0", host_data_read, device_address[31:0]);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_read();
    int lat, sc; logic [3:0] wo, ro;
    delay[1] = 1; rd_data[1] = 32'hCAFEF00D;
    run_txn(32'h1000, 1'b0, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 0, lat, sc, wo, ro);
    n_tests++;
    if (lat !== 3 || sc !== 1 || ro !== 4'b0010 || wo !== 4'b0000) begin
      n_fail++; $display("FAIL read: got lat %0d strobes %0d ren %b wen %b, required 3 1 0010 0000", lat, sc, ro, wo);
    end
  endtask

  task automatic test_write();
    int lat, sc; logic [3:0] wo, ro;
    delay[2] = 5;
    run_txn(32'h2000, 1'b1, 32'h12345678, 4'b0011, 32'h0, 1'b0, 0, lat, sc, wo, ro);
    n_tests++;
    if (lat !== 7 || sc !== 5 || wo !== 4'b0100 || ro !== 4'b0000) begin
      n_fail++; $display("FAIL write: got lat %0d strobes %0d wen %b ren %b, required 7 5 0100 0000", lat, sc, wo, ro);
    end
    n_tests++;
    if (device_data_write[95:64] !== 32'h12345678 || device_write_mask[11:8] !== 4'b0011 ||
        device_address[127:96] !== 32'h2000) begin
      n_fail++; $display("FAIL broadcast: got data %h mask %b addr %h, required 12345678 0011 00002000",
                         device_data_write[95:64], device_write_mask[11:8], device_address[127:96]);
    end
  endtask

  task automatic test_priority();
    int lat, sc; logic [3:0] wo, ro;
    delay[0] = 3; rd_data[0] = 32'h11110000; force_rdy[3] = 1'b1;
    run_txn(32'h3000, 1'b0, 32'h0, 4'h0, 32'h11110000, 1'b0, 0, lat, sc, wo, ro);
    force_rdy[3] = 1'b0;
    n_tests++;
    if (ro !== 4'b0001 || lat !== 5 || sc !== 3) begin
      n_fail++; $display("FAIL priority: got ren %b lat %0d strobes %0d, required 0001 5 3", ro, lat, sc);
    end
  endtask

  task automatic test_unmapped();
    int lat, sc; logic [3:0] wo, ro;
    run_txn(32'h5000, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1, 0, lat, sc, wo, ro);
    n_tests++;
    if (lat !== 2 || sc !== 0) begin
      n_fail++; $display("FAIL unmapped: got lat %0d strobes %0d, required 2 0", lat, sc);
    end
  endtask

  task automatic test_timeout();
    int lat, sc, extra; logic [3:0] wo, ro;
    delay[1] = 0;
    run_txn(32'h1000, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1, 4, lat, sc, wo, ro);
    n_tests++;
    if (lat !== 2 + T || sc !== T || ro !== 4'b0010) begin
      n_fail++; $display("FAIL timeout: got lat %0d strobes %0d ren %b, required %0d %0d 0010", lat, sc, ro, 2 + T, T);
    end
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (host_ready || (device_wen | device_ren) != '0) extra++;
    end
    n_tests++;
    if (extra !== 0) begin
      n_fail++; $display("FAIL dropped_pulse: got %0d busy cycles after response, required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, lat3, sc; logic [3:0] wo, ro;
    delay[1] = 1; rd_data[1] = 32'hA5A50001;
    delay[2] = 1; rd_data[2] = 32'h5A5A0002;
    run_txn(32'h1004, 1'b0, 32'h0, 4'h0, 32'hA5A50001, 1'b0, 0, lat1, sc, wo, ro);
    run_txn(32'h2008, 1'b1, 32'h77, 4'hF, 32'h0, 1'b0, 0, lat2, sc, wo, ro);
    run_txn(32'h2000, 1'b0, 32'h0, 4'h0, 32'h5A5A0002, 1'b0, 0, lat3, sc, wo, ro);
    n_tests++;
    if (lat1 !== 3 || lat2 !== 3 || lat3 !== 3) begin
      n_fail++; $display("FAIL back_to_back: got lat %0d %0d %0d, required 3 3 3", lat1, lat2, lat3);
    end
    @(negedge clk); @(negedge clk);
    n_tests++;
    if (host_data_read !== 32'h5A5A0002) begin
      n_fail++; $display("FAIL data_hold: got %h, required 5a5a0002", host_data_read);
    end
  endtask

  task automatic test_reset_mid();
    int lat, sc; logic [3:0] wo, ro;
    delay[1] = 0;
    @(negedge clk);
    host_address = 32'h1000; host_ren = 1'b1;
    @(negedge clk); host_ren = 1'b0;
    @(negedge clk);
    n_tests++;
    if (device_ren !== 4'b0010) begin
      n_fail++; $display("FAIL mid_strobe: got %b, required 0010", device_ren);
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (device_ren !== '0 || device_wen !== '0 || host_ready !== 1'b0 ||
        host_data_read !== 32'h0 || device_address !== '0) begin
      n_fail++; $display("FAIL mid_reset: got ren %b ready %b data %h addr %h, required all 0",
                         device_ren, host_ready, host_data_read, device_address[31:0]);
    end
    @(negedge clk); rst = 1'b1;
    delay[1] = 1; rd_data[1] = 32'h600DCAFE;
    run_txn(32'h1000, 1'b0, 32'h0, 4'h0, 32'h600DCAFE, 1'b0, 0, lat, sc, wo, ro);
    n_tests++;
    if (lat !== 3 || ro !== 4'b0010) begin
      n_fail++; $display("FAIL after_reset: got lat %0d ren %b, required 3 0010", lat, ro);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rd_data[i] = 32'h0; delay[i] = 1; force_rdy[i] = 1'b0;
    end
    test_reset();
    test_read();
    test_write();
    test_priority();
    test_unmapped();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_tests++;
    if (sb.size() !== 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
